// File: rtl/output_port_alloc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : output_port_alloc_pkg                                           |
// | Brief    : Shared types and constants for the per-output switch allocator. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package output_port_alloc_pkg;

  // Input port identities; the numeric value is also the crossbar mux select.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam int         NUM_PORTS = 5;
  localparam int         SEL_W     = 3;
  localparam logic [2:0] SEL_NONE  = 3'b111;

  typedef logic [15:0] flit_t;

  // Allocator FSM: either scanning for a requester or locked to one packet.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Reduce a small sum (0..15) modulo 5 without a general divider.
  function automatic logic [2:0] mod5(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (r >= 4'd10) r = r - 4'd10;
    if (r >= 4'd5)  r = r - 4'd5;
    return r[2:0];
  endfunction

endpackage : output_port_alloc_pkg
`default_nettype wire

// File: rtl/output_port_alloc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : output_port_alloc_if                                            |
// | Brief    : Request/flit-status/select bundle between the input FIFOs, the  |
// |            downstream credit logic and one output-port allocator.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface output_port_alloc_if;
  import output_port_alloc_pkg::*;

  // Directions in the names are as seen by the allocator.
  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] valid_i;
  logic [NUM_PORTS-1:0] tail_i;
  logic                 ready_i;
  logic [SEL_W-1:0]     sel_o;
  logic [NUM_PORTS-1:0] grant_o;
  logic [NUM_PORTS-1:0] pop_o;
  logic                 valid_o;

  // Router side: FIFOs and credit logic drive requests and flit status.
  modport master (
    output req_i, valid_i, tail_i, ready_i,
    input  sel_o, grant_o, pop_o, valid_o
  );

  // Allocator side.
  modport slave (
    input  req_i, valid_i, tail_i, ready_i,
    output sel_o, grant_o, pop_o, valid_o
  );
endinterface : output_port_alloc_if
`default_nettype wire

// File: rtl/output_port_alloc_rr_arb5.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arb5                                                         |
// | Brief    : Combinational 5-way round-robin arbiter. Rotates the request    |
// |            vector so the port after ptr sits at position 0, takes the      |
// |            lowest set bit, and maps it back to an absolute port index.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arb5
  import output_port_alloc_pkg::*;
(
  input  wire  [NUM_PORTS-1:0] req_i,
  input  wire  [2:0]           ptr_i,
  output logic [NUM_PORTS-1:0] gnt_oh_o,
  output logic [2:0]           gnt_idx_o
);

  // w_map[k] is the absolute port checked k-th, starting at ptr+1.
  logic [2:0]           w_map [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_rot;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_rot
    assign w_map[k] = mod5({1'b0, ptr_i} + 4'(k + 1));
    assign w_rot[k] = req_i[w_map[k]];
  end

  // Priority pick on the rotated vector; descending scan so position 0 wins.
  always_comb begin
    gnt_idx_o = SEL_NONE;
    gnt_oh_o  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) gnt_idx_o = w_map[k];
    end
    if (|req_i) gnt_oh_o = NUM_PORTS'(1) << gnt_idx_o;
  end

endmodule : rr_arb5
`default_nettype wire

// File: rtl/output_port_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : output_port_alloc                                               |
// | Brief    : Per-output switch allocator. Round-robin picks one of the five  |
// |            inputs, holds the grant for a whole wormhole packet, drives the |
// |            crossbar mux select, per-input pop strobes and output valid.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module output_port_alloc
  import output_port_alloc_pkg::*;
#(
  parameter int         NUM_PORTS  = 5,
  parameter int         SEL_W      = 3,
  parameter logic [2:0] RR_RST_PTR = 3'd4
) (
  input wire                 clk_i,
  input wire                 rst_ni,
  output_port_alloc_if.slave bus
);

  state_e               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [SEL_W-1:0]     sel_q;
  logic [2:0]           ptr_q;

  logic [NUM_PORTS-1:0] w_arb_oh;
  logic [2:0]           w_arb_idx;
  logic                 w_locked;
  logic                 w_head_valid;
  logic                 w_head_tail;
  logic                 w_fire;

  rr_arb5 u_arb (
    .req_i     (bus.req_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (w_arb_oh),
    .gnt_idx_o (w_arb_idx)
  );

  // Only the granted input's status bits matter; masking with the one-hot
  // grant is the same as indexing by sel but never touches an idle select.
  assign w_locked     = (state_q == ST_LOCKED);
  assign w_head_valid = |(bus.valid_i & grant_q);
  assign w_head_tail  = |(bus.tail_i & grant_q);
  // Qualified by rst_ni so a reset cycle can never pop a FIFO.
  assign w_fire       = w_locked & w_head_valid & bus.ready_i & rst_ni;

  assign bus.valid_o  = w_locked & w_head_valid & rst_ni;
  assign bus.pop_o    = w_fire ? grant_q : '0;
  assign bus.grant_o  = grant_q;
  assign bus.sel_o    = sel_q;

  // Allocator FSM: arbitrate in IDLE, hold the lock until the tail flit fires.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= SEL_NONE;
      ptr_q   <= RR_RST_PTR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_i) begin
            grant_q <= w_arb_oh;
            sel_q   <= w_arb_idx;
            state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Pointer lands on the released port so it is last in line next time.
          if (w_fire && w_head_tail) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= SEL_NONE;
            ptr_q   <= sel_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          sel_q   <= SEL_NONE;
        end
      endcase
    end
  end

endmodule : output_port_alloc
`default_nettype wire

// File: tb/tb_output_port_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_output_port_alloc                                            |
// | Brief    : Directed vector table, reset/lock corner sequences and a random |
// |            packet-source soak for output_port_alloc.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_output_port_alloc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_port_alloc_if bus ();

  output_port_alloc #(
    .NUM_PORTS  (5),
    .SEL_W      (3),
    .RR_RST_PTR (3'd4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] vld;
    logic [4:0] tl;
    logic       rdy;
    logic [2:0] sel;
    logic [4:0] gnt;
    logic [4:0] pop;
    logic       vo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                     input logic [4:0] tl, input logic rd, input logic [2:0] s,
                     input logic [4:0] g, input logic [4:0] p, input logic v);
    vec_t e;
    e.rst_n = r; e.req = rq; e.vld = vl; e.tl = tl; e.rdy = rd;
    e.sel = s; e.gnt = g; e.pop = p; e.vo = v;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                       input logic [4:0] tl, input logic rd);
    rst_n       = r;
    bus.req_i   = rq;
    bus.valid_i = vl;
    bus.tail_i  = tl;
    bus.ready_i = rd;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] s, input logic [4:0] g,
                            input logic [4:0] p, input logic v);
    check({tag, " sel"},   32'(bus.sel_o),   32'(s));
    check({tag, " grant"}, 32'(bus.grant_o), 32'(g));
    check({tag, " pop"},   32'(bus.pop_o),   32'(p));
    check({tag, " valid"}, 32'(bus.valid_o), 32'(v));
  endtask

  // Random-phase packet sources.
  logic       pend [5];
  int         rem  [5];
  int         wait_cnt [5];
  logic [4:0] prev_grant;
  logic       prev_tail_pop;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset with everything asserted: outputs must stay quiet.
    drive(1'b0, 5'h1F, 5'h1F, 5'h1F, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check_outs("reset", 3'd7, 5'b0, 5'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b1);

    // Single W packet (head+tail) from reset.
    add(1, 5'b00100, 5'b00100, 5'b00100, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'b00100, 5'b00100, 5'b00100, 1, 3'd2, 5'b00100, 5'b00100, 1);
    add(1, 5'b00000, 5'b00000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(0, 5'b00000, 5'b00000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);
    // All five requesting, single-flit packets: N,S,W,E,L,N with bubbles.
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd0, 5'b00001, 5'b00001, 1);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd1, 5'b00010, 5'b00010, 1);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd2, 5'b00100, 5'b00100, 1);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd3, 5'b01000, 5'b01000, 1);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd4, 5'b10000, 5'b10000, 1);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'h1F, 5'h1F, 5'h1F, 1, 3'd0, 5'b00001, 5'b00001, 1);
    add(1, 5'b00000, 5'b00000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);
    // 4-flit E packet, 2-cycle stall, N requesting throughout.
    add(1, 5'b01000, 5'b01000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'b01001, 5'b01001, 5'b00000, 1, 3'd3, 5'b01000, 5'b01000, 1);
    add(1, 5'b01001, 5'b01001, 5'b00001, 0, 3'd3, 5'b01000, 5'b00000, 1);
    add(1, 5'b01001, 5'b01001, 5'b00000, 0, 3'd3, 5'b01000, 5'b00000, 1);
    add(1, 5'b01001, 5'b01001, 5'b00000, 1, 3'd3, 5'b01000, 5'b01000, 1);
    add(1, 5'b01001, 5'b01001, 5'b00000, 1, 3'd3, 5'b01000, 5'b01000, 1);
    add(1, 5'b01001, 5'b01001, 5'b01001, 1, 3'd3, 5'b01000, 5'b01000, 1);
    add(1, 5'b00001, 5'b00001, 5'b00001, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'b00001, 5'b00001, 5'b00001, 1, 3'd0, 5'b00001, 5'b00001, 1);
    // S granted, 3-cycle valid gap (request dropped, other valids ignored).
    add(1, 5'b00010, 5'b00000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);
    add(1, 5'b00010, 5'b00000, 5'b00000, 1, 3'd1, 5'b00010, 5'b00000, 0);
    add(1, 5'b00000, 5'b00101, 5'b00101, 1, 3'd1, 5'b00010, 5'b00000, 0);
    add(1, 5'b00000, 5'b00000, 5'b00000, 1, 3'd1, 5'b00010, 5'b00000, 0);
    add(1, 5'b00000, 5'b00010, 5'b00010, 1, 3'd1, 5'b00010, 5'b00010, 1);
    add(1, 5'b00000, 5'b00000, 5'b00000, 1, 3'd7, 5'b00000, 5'b00000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].vld, tbl[i].tl, tbl[i].rdy);
      #2;
      check_outs($sformatf("row%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].pop, tbl[i].vo);
    end

    // Reset mid-packet: lock on W dropped, pointer back to L (ptr was S).
    @(negedge clk);
    drive(1'b1, 5'b00100, 5'b00100, 5'b00000, 1'b1);
    #2; check_outs("mrst idle", 3'd7, 5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    #2; check_outs("mrst flit1", 3'd2, 5'b00100, 5'b00100, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2; check_outs("mrst during", 3'd2, 5'b00100, 5'b00000, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'h1F, 5'b00100, 5'b00000, 1'b1);
    #2; check_outs("mrst after", 3'd7, 5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'h1F, 5'b00000, 5'b00000, 1'b1);
    #2; check_outs("mrst regrant", 3'd0, 5'b00001, 5'b00000, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'b00000, 5'b00001, 5'b00001, 1'b1);
    #2; check_outs("mrst ntail", 3'd0, 5'b00001, 5'b00001, 1'b1);

    // Random soak with packet sources that hold req until their tail pops.
    for (int p = 0; p < 5; p++) begin pend[p] = 1'b0; rem[p] = 0; wait_cnt[p] = 0; end
    prev_grant    = 5'b0;
    prev_tail_pop = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [4:0] rq, vl, tl, g, exp_pop;
      logic       rd, exp_v, inv_ok, lock_ok, tail_pop;
      @(negedge clk);
      for (int p = 0; p < 5; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1; rem[p] = int'($urandom_range(1, 4)); wait_cnt[p] = 0;
        end
        rq[p] = pend[p];
        vl[p] = pend[p] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        tl[p] = pend[p] ? (rem[p] == 1) : 1'($urandom_range(0, 1));
      end
      rd = ($urandom_range(0, 4) != 0);
      drive(1'b1, rq, vl, tl, rd);
      #2;
      g       = bus.grant_o;
      exp_v   = |(vl & g);
      exp_pop = (exp_v && rd) ? g : 5'b0;
      check("rnd pop", 32'(bus.pop_o), 32'(exp_pop));
      check("rnd valid", 32'(bus.valid_o), 32'(exp_v));
      inv_ok = (g == 5'b0) ? (bus.sel_o == 3'd7)
                           : ($onehot(g) && bus.sel_o < 3'd5 &&
                              g == (5'b00001 << bus.sel_o) && pend[bus.sel_o]);
      check("rnd grant/sel invariant", 32'(inv_ok), 32'd1);
      if (prev_tail_pop)          lock_ok = (g == 5'b0);
      else if (prev_grant != 5'b0) lock_ok = (g == prev_grant);
      else                         lock_ok = 1'b1;
      check("rnd lock hold", 32'(lock_ok), 32'd1);
      if (prev_grant == 5'b0 && g != 5'b0)
        check("rnd starvation", 32'(wait_cnt[bus.sel_o] <= 4), 32'd1);
      tail_pop = 1'b0;
      for (int p = 0; p < 5; p++) begin
        if (bus.pop_o[p]) begin
          rem[p]--;
          if (rem[p] == 0) begin
            pend[p]  = 1'b0;
            tail_pop = 1'b1;
            for (int q = 0; q < 5; q++) if (q != p && pend[q]) wait_cnt[q]++;
          end
        end
      end
      prev_grant    = g;
      prev_tail_pop = tail_pop;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_output_port_alloc
`default_nettype wire
